seq_dev_port: RTL and testbench

Device-side endpoint of the sequencer command bus. It accepts the 12-bit command word addressed to one device through its one-hot write-enable bit and buffers it in a small FIFO. It presents buffered commands to the device core over a valid/ready handshake, and registers the core's 8-bit result for the sequencer's `ireg_n` input. One instance sits in front of each of the up to eight devices on the bus.

---
 rtl/seq_dev_port_pkg.sv | 35 +++
 rtl/seq_dev_fifo.sv | 68 ++++++
 rtl/seq_dev_port.sv | 118 +++++++++++
 tb/tb_seq_dev_port.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_dev_port_pkg.sv
// Shared sequencer/device bus definitions.
// State encodings, clear opcode and oreg field layout.
package seq_dev_port_pkg;

  typedef enum logic [1:0] {
    SeqDev_State_Reset = 2'h0,
    SeqDev_State_Ready = 2'h1,
    SeqDev_State_Error = 2'h2
  } seq_dev_state_e;

  localparam logic [3:0] SeqDev_CMD_CLEAR = 4'hF;

  localparam int SeqDev_CMD_MSB = 11;
  localparam int SeqDev_CMD_LSB = 8;
  localparam int SeqDev_ARG_MSB = 7;
  localparam int SeqDev_ARG_LSB = 0;

  localparam int SeqDev_WORD_W = 12;
  localparam int SeqDev_WEN_W  = 8;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] arg;
  } seq_dev_word_t;

  function automatic seq_dev_word_t seq_dev_unpack(
    input logic [SeqDev_WORD_W-1:0] w
  );
    seq_dev_word_t r;
    r.cmd = w[SeqDev_CMD_MSB:SeqDev_CMD_LSB];
    r.arg = w[SeqDev_ARG_MSB:SeqDev_ARG_LSB];
    return r;
  endfunction

endpackage

// File: rtl/seq_dev_fifo.sv
// Show-ahead command FIFO for one device port.
// Flush has priority over push and pop.
module seq_dev_fifo #(
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = 3,
  parameter int DATA_W  = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout,
  output logic               empty,
  output logic               full,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = LEVEL_W - 1;
  localparam logic [LEVEL_W-1:0] FullLvl = LEVEL_W'(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign empty = (count == '0);
  assign full  = (count == FullLvl);
  assign level = count;
  assign dout  = mem[rd_ptr];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointer and occupancy tracking; pointers wrap at DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/seq_dev_port.sv
// Device-side endpoint of the sequencer command bus.
// Buffers strobed commands, hands them to the core, returns results.
module seq_dev_port
  import seq_dev_port_pkg::*;
#(
  parameter int DEV_ID     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_W    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        oreg,
  input  logic [7:0]         oreg_wen,
  output logic [3:0]         cmd,
  output logic [7:0]         arg,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  input  logic [7:0]         result,
  input  logic               result_wen,
  output logic [7:0]         ireg,
  output logic               overflow,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [2:0] DevSel = 3'(DEV_ID);

  seq_dev_state_e     state_q;
  seq_dev_state_e     state_d;
  seq_dev_word_t      wr_word;
  seq_dev_word_t      head;
  logic [11:0]        fifo_dout;
  logic               fifo_empty;
  logic               fifo_full;
  logic [LEVEL_W-1:0] fifo_level;
  logic               in_ready;
  logic               in_reset;
  logic               wr_hit;
  logic               clear_hit;
  logic               push_req;
  logic               pop;
  logic               ovf_evt;
  logic               fifo_push;
  logic               fifo_flush;

  assign in_ready = (state_q == SeqDev_State_Ready);
  assign in_reset = (state_q == SeqDev_State_Reset);
  assign wr_word  = seq_dev_unpack(oreg);
  assign wr_hit   = in_ready && oreg_wen[DevSel];

  assign clear_hit = wr_hit && (wr_word.cmd == SeqDev_CMD_CLEAR);
  assign push_req  = wr_hit && !clear_hit;

  assign cmd_valid = in_ready && !fifo_empty;
  assign pop       = cmd_valid && cmd_ready;

  assign ovf_evt    = push_req && fifo_full && !pop;
  assign fifo_push  = push_req && !ovf_evt;
  assign fifo_flush = clear_hit || ovf_evt;

  assign head  = fifo_dout;
  assign cmd   = head.cmd;
  assign arg   = head.arg;
  assign level = fifo_level;

  seq_dev_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W),
    .DATA_W  (12)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .flush (fifo_flush),
    .din   (oreg),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Port state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= SeqDev_State_Reset;
    else        state_q <= state_d;
  end

  // Next state: leave Reset on first clock, trap in Error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SeqDev_State_Reset: state_d = SeqDev_State_Ready;
      SeqDev_State_Ready: begin
        if (ovf_evt) state_d = SeqDev_State_Error;
      end
      SeqDev_State_Error: state_d = SeqDev_State_Error;
      default:            state_d = SeqDev_State_Error;
    endcase
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
  end

  // Result register; a clear beats a same-cycle result write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ireg <= '0;
    end else if (clear_hit) begin
      ireg <= '0;
    end else if (result_wen && !in_reset) begin
      ireg <= result;
    end
  end

endmodule

// File: tb/tb_seq_dev_port.sv
// Self-checking bench for seq_dev_port (DEV_ID=2, depth 4).
// Vector table, directed corner cases, random vs queue model.
module tb_seq_dev_port;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] oreg = '0;
  logic [7:0]  oreg_wen = '0;
  logic [3:0]  cmd;
  logic [7:0]  arg;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  result = '0;
  logic        result_wen = 1'b0;
  logic [7:0]  ireg;
  logic        overflow;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  seq_dev_port #(
    .DEV_ID     (2),
    .FIFO_DEPTH (4),
    .LEVEL_W    (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .oreg       (oreg),
    .oreg_wen   (oreg_wen),
    .cmd        (cmd),
    .arg        (arg),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .result     (result),
    .result_wen (result_wen),
    .ireg       (ireg),
    .overflow   (overflow),
    .level      (level)
  );

  typedef struct {
    logic [11:0] o;
    logic [7:0]  w;
    logic        rdy;
    logic [7:0]  rs;
    logic        rw;
    logic        ev;
    logic [3:0]  ecmd;
    logic [7:0]  earg;
    logic [2:0]  elvl;
    logic [7:0]  eireg;
    logic        eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [11:0] o, input logic [7:0] w, input logic rdy,
    input logic [7:0] rs, input logic rw,
    input logic ev, input logic [3:0] ecmd, input logic [7:0] earg,
    input logic [2:0] elvl, input logic [7:0] eireg, input logic eovf
  );
    vec_t v;
    v.o = o; v.w = w; v.rdy = rdy; v.rs = rs; v.rw = rw;
    v.ev = ev; v.ecmd = ecmd; v.earg = earg;
    v.elvl = elvl; v.eireg = eireg; v.eovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev,
                         input logic [3:0] ec, input logic [7:0] ea,
                         input logic [2:0] el, input logic [7:0] ei,
                         input logic eo);
    check({tag, ".valid"}, 32'(cmd_valid), 32'(ev));
    check({tag, ".level"}, 32'(level), 32'(el));
    check({tag, ".ireg"}, 32'(ireg), 32'(ei));
    check({tag, ".ovf"}, 32'(overflow), 32'(eo));
    if (ev) check({tag, ".head"}, {20'h0, cmd, arg}, {20'h0, ec, ea});
  endtask

  task automatic step(input logic [11:0] o, input logic [7:0] w,
                      input logic rdy, input logic [7:0] rs,
                      input logic rw);
    @(negedge clock);
    oreg = o; oreg_wen = w; cmd_ready = rdy;
    result = rs; result_wen = rw;
    @(posedge clock);
    #1;
  endtask

  // Reference model: a queue of pending words plus port mode.
  localparam int M_RST = 0;
  localparam int M_RDY = 1;
  localparam int M_ERR = 2;

  int          m_mode;
  logic [11:0] m_q[$];
  logic [7:0]  m_ireg;
  logic        m_ovf;

  task automatic model_edge();
    bit vld, pp, hit, clr;
    if (!reset) begin
      m_mode = M_RST; m_q.delete(); m_ireg = 0; m_ovf = 0;
      return;
    end
    if (m_mode == M_RST) begin
      m_mode = M_RDY;
      return;
    end
    clr = 0;
    if (m_mode == M_RDY) begin
      vld = (m_q.size() > 0);
      pp  = vld && cmd_ready;
      hit = oreg_wen[2];
      if (hit && oreg[11:8] == 4'hF) begin
        m_q.delete();
        clr = 1;
      end else if (hit && m_q.size() == 4 && !pp) begin
        m_ovf = 1; m_mode = M_ERR; m_q.delete();
      end else begin
        if (pp) void'(m_q.pop_front());
        if (hit) m_q.push_back(oreg);
      end
    end
    if (clr) m_ireg = 0;
    else if (result_wen) m_ireg = result;
  endtask

  initial begin
    logic [11:0] hd;
    bit ev;
    int r;

    // Reset is low from time zero.
    #1;
    chk_out("rst0", 1'b0, 4'h0, 8'h0, 3'd0, 8'h0, 1'b0);
    check("rst0.head", {20'h0, cmd, arg}, 32'h0);
    repeat (3) @(posedge clock);
    // Release with a write pending: first edge only leaves Reset.
    @(negedge clock);
    reset = 1'b1;
    oreg = 12'h3A5; oreg_wen = 8'h04; cmd_ready = 1'b1;
    @(posedge clock);
    #1;
    chk_out("first_edge_drop", 1'b0, 4'h0, 8'h0, 3'd0, 8'h0, 1'b0);

    tbl.push_back(mk(12'h3A5, 8'h04, 1, 8'h00, 0, 1, 4'h3, 8'hA5, 1, 8'h00, 0));
    tbl.push_back(mk(12'h000, 8'h00, 1, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0));
    tbl.push_back(mk(12'h101, 8'h04, 0, 8'h33, 1, 1, 4'h1, 8'h01, 1, 8'h33, 0));
    tbl.push_back(mk(12'h202, 8'h04, 0, 8'h00, 0, 1, 4'h1, 8'h01, 2, 8'h33, 0));
    tbl.push_back(mk(12'h303, 8'h04, 0, 8'h00, 0, 1, 4'h1, 8'h01, 3, 8'h33, 0));
    tbl.push_back(mk(12'h404, 8'h04, 0, 8'h00, 0, 1, 4'h1, 8'h01, 4, 8'h33, 0));
    tbl.push_back(mk(12'h000, 8'h00, 0, 8'h00, 0, 1, 4'h1, 8'h01, 4, 8'h33, 0));
    tbl.push_back(mk(12'h505, 8'h04, 1, 8'h00, 0, 1, 4'h2, 8'h02, 4, 8'h33, 0));
    tbl.push_back(mk(12'h000, 8'h00, 1, 8'h00, 0, 1, 4'h3, 8'h03, 3, 8'h33, 0));
    tbl.push_back(mk(12'h000, 8'h00, 1, 8'h00, 0, 1, 4'h4, 8'h04, 2, 8'h33, 0));
    tbl.push_back(mk(12'h000, 8'h00, 1, 8'h00, 0, 1, 4'h5, 8'h05, 1, 8'h33, 0));
    tbl.push_back(mk(12'h000, 8'h00, 1, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h33, 0));
    tbl.push_back(mk(12'h111, 8'h04, 0, 8'h00, 0, 1, 4'h1, 8'h11, 1, 8'h33, 0));
    tbl.push_back(mk(12'h222, 8'h04, 0, 8'h00, 0, 1, 4'h1, 8'h11, 2, 8'h33, 0));
    tbl.push_back(mk(12'h333, 8'h04, 0, 8'h00, 0, 1, 4'h1, 8'h11, 3, 8'h33, 0));
    tbl.push_back(mk(12'h444, 8'h04, 0, 8'h00, 0, 1, 4'h1, 8'h11, 4, 8'h33, 0));
    tbl.push_back(mk(12'h606, 8'h04, 0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h33, 1));
    tbl.push_back(mk(12'h707, 8'h04, 0, 8'h77, 1, 0, 4'h0, 8'h00, 0, 8'h77, 1));
    tbl.push_back(mk(12'hF00, 8'h04, 1, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h77, 1));

    foreach (tbl[i]) begin
      step(tbl[i].o, tbl[i].w, tbl[i].rdy, tbl[i].rs, tbl[i].rw);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ecmd,
              tbl[i].earg, tbl[i].elvl, tbl[i].eireg, tbl[i].eovf);
    end

    // Reset pulse recovers from Error.
    @(negedge clock);
    oreg_wen = 8'h00;
    reset = 1'b0;
    #1;
    chk_out("err_rst", 1'b0, 4'h0, 8'h0, 3'd0, 8'h00, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(12'h000, 8'h00, 0, 8'h00, 0);
    step(12'h0AB, 8'h04, 0, 8'h00, 0);
    chk_out("ready_again", 1'b1, 4'h0, 8'hAB, 3'd1, 8'h00, 1'b0);
    step(12'h0CD, 8'h04, 0, 8'h00, 0);
    chk_out("push2", 1'b1, 4'h0, 8'hAB, 3'd2, 8'h00, 1'b0);

    // Clear beats a same-cycle result write and pop.
    step(12'hF00, 8'h04, 1, 8'h5C, 1);
    chk_out("clear_wins", 1'b0, 4'h0, 8'h0, 3'd0, 8'h00, 1'b0);
    step(12'h000, 8'h00, 0, 8'h5C, 1);
    chk_out("result_load", 1'b0, 4'h0, 8'h0, 3'd0, 8'h5C, 1'b0);

    // Foreign strobes never push.
    step(12'h9EE, 8'h08, 0, 8'h00, 0);
    chk_out("foreign08", 1'b0, 4'h0, 8'h0, 3'd0, 8'h5C, 1'b0);
    step(12'h9EE, 8'hFB, 0, 8'h00, 0);
    chk_out("foreignFB", 1'b0, 4'h0, 8'h0, 3'd0, 8'h5C, 1'b0);
    step(12'h812, 8'h04, 0, 8'h00, 0);
    step(12'h834, 8'h04, 0, 8'h00, 0);
    chk_out("pre_async", 1'b1, 4'h8, 8'h12, 3'd2, 8'h5C, 1'b0);

    // Asynchronous reset mid-cycle, no clock edge needed.
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'h0, 8'h0, 3'd0, 8'h00, 1'b0);
    check("async_rst.head", {20'h0, cmd, arg}, 32'h0);

    // Random traffic against the queue model.
    m_mode = M_RST; m_q.delete(); m_ireg = 0; m_ovf = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clock);
      reset = (i % 150 != 149);
      r = $urandom_range(0, 3);
      oreg = 12'($urandom);
      oreg_wen = (r == 1) ? 8'h00 : (r == 2) ? 8'($urandom) : 8'h04;
      cmd_ready = ($urandom_range(0, 2) == 0);
      result = 8'($urandom);
      result_wen = ($urandom_range(0, 3) == 0);
      model_edge();
      @(posedge clock);
      #1;
      ev = (m_mode == M_RDY) && (m_q.size() > 0);
      hd = ev ? m_q[0] : 12'h0;
      total++;
      if (cmd_valid !== ev || level !== 3'(m_q.size()) ||
          ireg !== m_ireg || overflow !== m_ovf ||
          (ev && {cmd, arg} !== hd)) begin
        bad++;
        $display("FAIL rand%0d actual v=%b l=%0d i=%h o=%b h=%h required v=%b l=%0d i=%h o=%b h=%h",
                 i, cmd_valid, level, ireg, overflow, {cmd, arg},
                 ev, m_q.size(), m_ireg, m_ovf, hd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
